// File: rtl/dna_pkg.sv
// Shared DNA strand types and constants for the strand feeder path.
package dna_pkg;

  localparam int DEFAULT_STRAND_LEN = 16;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT,
    DONE,
    GUARD
  } feeder_state_t;

  // C and G bases are the ones that count toward GC content.
  function automatic logic is_gc(input base_t b);
    return (b == BASE_C) || (b == BASE_G);
  endfunction

endpackage

// File: rtl/strand_feeder_base_serializer.sv
// base_serializer: holds one strand word and steps through its 2-bit bases
// LSB first. It tracks the base index and raises last/done on the final base.
// With STRAND_FEEDER_GC_EN it also counts the C/G bases that are handshaken.
module base_serializer
  import dna_pkg::*;
#(
  parameter int STRAND_LEN = DEFAULT_STRAND_LEN,
  localparam int CNT_W     = $clog2(STRAND_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [2*STRAND_LEN-1:0] load_data,
  input  logic                    shift,
  output base_t                   base,
  output logic                    last,
  output logic                    done
`ifdef STRAND_FEEDER_GC_EN
  ,
  output logic [CNT_W-1:0]        gc_count
`endif
);

  logic [2*STRAND_LEN-1:0] shreg;
  logic [CNT_W-1:0]        cnt;

  assign base = base_t'(shreg[1:0]);
  assign last = (cnt == CNT_W'(STRAND_LEN - 1));
  assign done = shift & last;

  // Word capture, then shift right one base for each accepted handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        shreg <= '0;
    else if (load)  shreg <= load_data;
    else if (shift) shreg <= {2'b00, shreg[2*STRAND_LEN-1:2]};
  end

  // Base index within the strand. It reaches STRAND_LEN after the final base,
  // so last stays low outside the shifting phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (load)  cnt <= '0;
    else if (shift) cnt <= cnt + 1'b1;
  end

`ifdef STRAND_FEEDER_GC_EN
  // GC accumulator. It only moves on handshakes, so it holds from DONE until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       gc_count <= '0;
    else if (load)                 gc_count <= '0;
    else if (shift && is_gc(base)) gc_count <= gc_count + 1'b1;
  end
`endif

endmodule

// File: rtl/strand_feeder.sv
// strand_feeder: fetches one strand per load_on iteration from a synchronous
// memory and streams its bases to the correlator. It pulses cor_ready when the
// last base has been accepted. All outputs are decoded from registers.
// Optional feature macro: STRAND_FEEDER_GC_EN (adds the gc_count port).
module strand_feeder
  import dna_pkg::*;
#(
  parameter int STRAND_LEN = DEFAULT_STRAND_LEN,
  parameter int ADDR_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_on,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [2*STRAND_LEN-1:0] mem_rd_data,
  output logic                    base_valid,
  output logic [1:0]              base,
  output logic                    base_last,
  input  logic                    base_ready,
  output logic                    cor_ready,
  output logic [31:0]             strand_idx
`ifdef STRAND_FEEDER_GC_EN
  ,
  output logic [$clog2(STRAND_LEN+1)-1:0] gc_count
`endif
);

  feeder_state_t state, state_nxt;
  base_t         ser_base;
  logic          ser_last, ser_done, hs;

  assign hs = base_valid & base_ready;

  base_serializer #(.STRAND_LEN(STRAND_LEN)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (state == WAIT),
    .load_data (mem_rd_data),
    .shift     (hs),
    .base      (ser_base),
    .last      (ser_last),
    .done      (ser_done)
`ifdef STRAND_FEEDER_GC_EN
    ,
    .gc_count  (gc_count)
`endif
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completed-strand counter. It wraps naturally at 2^32, and its low bits
  // give the fetch address, which wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 strand_idx <= '0;
    else if (state == DONE)  strand_idx <= strand_idx + 32'd1;
  end

  // Next-state logic and Moore output decode. GUARD absorbs the one-cycle
  // lag of upstream load_on after the final cor_ready.
  always_comb begin
    state_nxt  = state;
    mem_rd_en  = 1'b0;
    base_valid = 1'b0;
    cor_ready  = 1'b0;
    mem_addr   = strand_idx[ADDR_W-1:0];
    base       = ser_base;
    base_last  = 1'b0;
    case (state)
      IDLE:  if (load_on) state_nxt = FETCH;
      FETCH: begin
        mem_rd_en = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  state_nxt = SHIFT;
      SHIFT: begin
        base_valid = 1'b1;
        base_last  = ser_last;
        if (ser_done) state_nxt = DONE;
      end
      DONE: begin
        cor_ready = 1'b1;
        state_nxt = GUARD;
      end
      GUARD:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_strand_feeder.sv
// Directed testbench for strand_feeder with STRAND_LEN=4 and ADDR_W=2.
// Define STRAND_FEEDER_GC_EN to also exercise gc_count.
module tb_strand_feeder;

  localparam int LEN = 4;
  localparam int AW  = 2;
  localparam int CW  = $clog2(LEN + 1);

  logic            clk = 1'b0;
  logic            rst, load_on, base_ready;
  logic            mem_rd_en, base_valid, base_last, cor_ready;
  logic [AW-1:0]   mem_addr;
  logic [2*LEN-1:0] mem_rd_data = '0;
  logic [1:0]      base;
  logic [31:0]     strand_idx;
`ifdef STRAND_FEEDER_GC_EN
  logic [CW-1:0]   gc_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] mem [4];
  int addr_q[$];
  int base_q[$];
  int cor_q[$];
  int gc_q[$];

  always #5 clk = ~clk;

  strand_feeder #(.STRAND_LEN(LEN), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_on     (load_on),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .base_valid  (base_valid),
    .base        (base),
    .base_last   (base_last),
    .base_ready  (base_ready),
    .cor_ready   (cor_ready),
    .strand_idx  (strand_idx)
`ifdef STRAND_FEEDER_GC_EN
    ,
    .gc_count    (gc_count)
`endif
  );

  // Synchronous strand memory: data one cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // Passive observer on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (mem_rd_en) addr_q.push_back(int'(mem_addr));
      if (base_valid && base_ready) base_q.push_back(int'(base));
      if (cor_ready) begin
        cor_q.push_back(cyc);
`ifdef STRAND_FEEDER_GC_EN
        gc_q.push_back(int'(gc_count));
`endif
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; load_on = 1'b0; base_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    addr_q.delete(); base_q.delete(); cor_q.delete(); gc_q.delete();
  endtask

  // Wait for n cor_ready pulses. Then drop load_on with the upstream
  // one-cycle lag, so load_on is still high during GUARD.
  task automatic run_until_cor(input int n, output bit ok);
    int c = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cor_ready) c++;
      if (c == n) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    @(posedge clk);
    #1 load_on = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; load_on = 1'b1; base_ready = 1'b1;
    #2;
    n_chk++; if (mem_rd_en !== 1'b0)   begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
    n_chk++; if (mem_addr !== '0)      begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    n_chk++; if (base_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", base_valid); end
    n_chk++; if (base !== 2'd0)        begin n_fail++; $display("FAIL reset_base: got %0d want 0", base); end
    n_chk++; if (base_last !== 1'b0)   begin n_fail++; $display("FAIL reset_last: got %b want 0", base_last); end
    n_chk++; if (cor_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_cor: got %b want 0", cor_ready); end
    n_chk++; if (strand_idx !== 32'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", strand_idx); end
`ifdef STRAND_FEEDER_GC_EN
    n_chk++; if (gc_count !== '0)      begin n_fail++; $display("FAIL reset_gc: got %0d want 0", gc_count); end
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; load_on = 1'b0;
  endtask

  task automatic test_three_strands();
    int exp_b[12] = '{3,2,1,0, 0,1,2,3, 0,0,0,0};
    bit ok;
    do_reset();
    mem[0] = 8'h1B; mem[1] = 8'hE4; mem[2] = 8'h00; mem[3] = 8'hFF;
    load_on = 1'b1;
    run_until_cor(3, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL three_timeout: got %0d pulses want 3", cor_q.size()); end
    n_chk++; if (base_q.size() != 12) begin n_fail++; $display("FAIL three_nbases: got %0d want 12", base_q.size()); end
    for (int i = 0; i < 12 && i < base_q.size(); i++) begin
      n_chk++; if (base_q[i] != exp_b[i]) begin n_fail++; $display("FAIL three_base[%0d]: got %0d want %0d", i, base_q[i], exp_b[i]); end
    end
    n_chk++; if (cor_q.size() != 3) begin n_fail++; $display("FAIL three_ncor: got %0d want 3", cor_q.size()); end
    if (cor_q.size() >= 3) begin
      n_chk++; if (cor_q[1] - cor_q[0] != 9) begin n_fail++; $display("FAIL three_period0: got %0d want 9", cor_q[1] - cor_q[0]); end
      n_chk++; if (cor_q[2] - cor_q[1] != 9) begin n_fail++; $display("FAIL three_period1: got %0d want 9", cor_q[2] - cor_q[1]); end
    end
    n_chk++; if (strand_idx !== 32'd3) begin n_fail++; $display("FAIL three_idx: got %0d want 3", strand_idx); end
    // load_on is still high during GUARD, so the guard alone must block a 4th fetch.
    n_chk++; if (addr_q.size() != 3) begin n_fail++; $display("FAIL guard_rd_count: got %0d want 3", addr_q.size()); end
  endtask

  task automatic test_backpressure();
    int exp_b[4] = '{3,2,1,0};
    int hs = 0;
    bit got = 1'b0, prev_stall = 1'b0;
    logic [1:0] pb = '0;
    logic pl = 1'b0;
    do_reset();
    mem[0] = 8'h1B;
    load_on = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (prev_stall && base_valid) begin
        n_chk++; if (base !== pb) begin n_fail++; $display("FAIL bp_hold_base: got %0d want %0d", base, pb); end
        n_chk++; if (base_last !== pl) begin n_fail++; $display("FAIL bp_hold_last: got %b want %b", base_last, pl); end
      end
      if (base_valid && base_ready) hs++;
      if (cor_ready) begin
        got = 1'b1;
        n_chk++; if (hs != 4) begin n_fail++; $display("FAIL bp_hs_at_cor: got %0d want 4", hs); end
        break;
      end
      prev_stall = base_valid & ~base_ready;
      pb = base; pl = base_last;
      @(posedge clk);
      #1 base_ready = ~base_ready;
    end
    n_chk++; if (!got) begin n_fail++; $display("FAIL bp_timeout: got no cor_ready want 1"); end
    @(posedge clk);
    @(posedge clk);
    #1 load_on = 1'b0; base_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++; if (base_q.size() != 4) begin n_fail++; $display("FAIL bp_nbases: got %0d want 4", base_q.size()); end
    for (int i = 0; i < 4 && i < base_q.size(); i++) begin
      n_chk++; if (base_q[i] != exp_b[i]) begin n_fail++; $display("FAIL bp_base[%0d]: got %0d want %0d", i, base_q[i], exp_b[i]); end
    end
    n_chk++; if (cor_q.size() != 1) begin n_fail++; $display("FAIL bp_ncor: got %0d want 1", cor_q.size()); end
  endtask

  task automatic test_reset_mid();
    int exp_b[4] = '{3,2,1,0};
    bit seen = 1'b0, ok;
    do_reset();
    mem[0] = 8'h1B;
    load_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (base_valid) begin seen = 1'b1; break; end
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL rmid_timeout: got no base_valid want 1"); end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_chk++; if (base_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", base_valid); end
    n_chk++; if (base !== 2'd0)       begin n_fail++; $display("FAIL rmid_base: got %0d want 0", base); end
    n_chk++; if (base_last !== 1'b0)  begin n_fail++; $display("FAIL rmid_last: got %b want 0", base_last); end
    n_chk++; if (cor_ready !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== '0 || strand_idx !== 32'd0) begin
      n_fail++; $display("FAIL rmid_others: got cor=%b rd=%b addr=%0d idx=%0d want all 0", cor_ready, mem_rd_en, mem_addr, strand_idx);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    addr_q.delete(); base_q.delete(); cor_q.delete();
    run_until_cor(1, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_cor_timeout: got %0d pulses want 1", cor_q.size()); end
    n_chk++; if (addr_q.size() < 1 || addr_q[0] != 0) begin n_fail++; $display("FAIL rmid_refetch: got %0d fetches want addr 0 first", addr_q.size()); end
    n_chk++; if (base_q.size() != 4) begin n_fail++; $display("FAIL rmid_nbases: got %0d want 4", base_q.size()); end
    for (int i = 0; i < 4 && i < base_q.size(); i++) begin
      n_chk++; if (base_q[i] != exp_b[i]) begin n_fail++; $display("FAIL rmid_base[%0d]: got %0d want %0d", i, base_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_addr_wrap();
    int exp_a[5] = '{0,1,2,3,0};
    bit ok;
    do_reset();
    mem[0] = 8'h1B; mem[1] = 8'hE4; mem[2] = 8'h00; mem[3] = 8'hFF;
    load_on = 1'b1;
    run_until_cor(5, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: got %0d pulses want 5", cor_q.size()); end
    n_chk++; if (addr_q.size() != 5) begin n_fail++; $display("FAIL wrap_nfetch: got %0d want 5", addr_q.size()); end
    for (int i = 0; i < 5 && i < addr_q.size(); i++) begin
      n_chk++; if (addr_q[i] != exp_a[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, addr_q[i], exp_a[i]); end
    end
    n_chk++; if (strand_idx !== 32'd5) begin n_fail++; $display("FAIL wrap_idx: got %0d want 5", strand_idx); end
  endtask

`ifdef STRAND_FEEDER_GC_EN
  task automatic test_gc();
    bit ok;
    do_reset();
    mem[0] = 8'h66; mem[1] = 8'hCC;
    load_on = 1'b1;
    run_until_cor(2, ok);
    n_chk++; if (!ok || gc_q.size() != 2) begin n_fail++; $display("FAIL gc_timeout: got %0d pulses want 2", gc_q.size()); end
    if (gc_q.size() >= 2) begin
      n_chk++; if (gc_q[0] != 4) begin n_fail++; $display("FAIL gc_0x66: got %0d want 4", gc_q[0]); end
      n_chk++; if (gc_q[1] != 0) begin n_fail++; $display("FAIL gc_0xCC: got %0d want 0", gc_q[1]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_three_strands();
    test_backpressure();
    test_reset_mid();
    test_addr_wrap();
`ifdef STRAND_FEEDER_GC_EN
    test_gc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/strand_feeder.md
# strand_feeder

Consumer side of the strand load handshake. While the upstream strand counter holds `load_on` high, it fetches one strand per iteration from a synchronous strand memory. It serializes the strand's 2-bit bases into the correlator under a valid/ready handshake, then pulses `cor_ready` for one cycle so the counter advances to the next strand.

## Interface
- `STRAND_LEN`, 16: bases per strand, ≥2.
- `ADDR_W`, 10: strand memory address width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load_on` in 1: strand counter request; level, registered upstream.
- `mem_rd_en` out 1: strand memory read strobe.
- `mem_addr` out ADDR_W: strand memory address.
- `mem_rd_data` in 2*STRAND_LEN: strand word; valid exactly one cycle after `mem_rd_en`.
- `base_valid` out 1: base available to the correlator.
- `base` out 2: base code, A=00 C=01 G=10 T=11.
- `base_last` out 1: the current base is the final base of the strand.
- `base_ready` in 1: correlator accepts the base.
- `cor_ready` out 1: one-cycle pulse; the strand is fully delivered.
- `strand_idx` out 32: number of strands completed since reset.
- `gc_count` out $clog2(STRAND_LEN+1): only with `STRAND_FEEDER_GC_EN`.

## Operation
- FSM states: IDLE, FETCH, WAIT, SHIFT, DONE, GUARD.
- IDLE: if `load_on`=1, go to FETCH; otherwise stay in IDLE.
- FETCH: `mem_rd_en`=1, `mem_addr`=`strand_idx[ADDR_W-1:0]`. Always goes to WAIT.
- WAIT: capture `mem_rd_data` into the shift register and clear the base counter. Go to SHIFT.
- SHIFT: `base_valid`=1 and `base`=shreg[1:0]; base 0 is the LSBs of the word.
  - On a handshake (`base_valid`&`base_ready`), shift right by 2 and increment the base counter.
  - `base_last`=1 when the base counter equals STRAND_LEN-1.
  - A handshake with `base_last`=1 goes to DONE.
  - While `base_ready`=0, `base` and `base_last` hold.
- DONE: `cor_ready`=1 and `strand_idx` increments. Go to GUARD.
- GUARD: one cycle that ignores `load_on`, because upstream `load_on` falls one cycle late after the final `cor_ready`. Then go to IDLE.
- Boundary conditions:
  - `load_on` falling mid-strand does not abort. The strand completes and `cor_ready` still pulses.
  - `mem_addr` wraps modulo 2^ADDR_W.
  - `strand_idx` wraps at 2^32.
  - `rst` mid-strand drops all outputs to reset values immediately and discards the partial strand; there is no `cor_ready`.
- Reset values: state IDLE. `mem_rd_en`, `mem_addr`, `base_valid`, `base`, `base_last`, `cor_ready`, `strand_idx`, `gc_count` are all 0. The shift register is 0.

## Timing
- All outputs are decoded from registered state and datapath (Moore). There is no combinational path from `base_ready` or `load_on` to any output.
- Latency: `load_on` seen high in IDLE at cycle t gives:
  - `mem_rd_en` at t+1;
  - data captured at the end of t+2;
  - first `base_valid` at t+3.
- With `base_ready` held at 1, the last base is at t+2+STRAND_LEN and `cor_ready` at t+3+STRAND_LEN.
- Strand period with `load_on` held and `base_ready` held at 1 is STRAND_LEN+5 cycles (IDLE, FETCH, WAIT, STRAND_LEN×SHIFT, DONE, GUARD).

## Configuration
- `STRAND_FEEDER_GC_EN` defined:
  - A GC accumulator adds 1 for each handshaken base equal to 01 or 10.
  - It clears in WAIT.
  - `gc_count` is valid and stable from DONE until the next WAIT.
- Not defined: the `gc_count` port and accumulator are absent, and all other behaviour is identical.

## Structure
- Shared package `dna_pkg`:
  - `base_t` (2-bit enum BASE_A/C/G/T);
  - `feeder_state_t` enum;
  - `DEFAULT_STRAND_LEN` constant.
- One sub-module, `base_serializer`: shift register, base counter, `base_last`, and the optional GC accumulator. Its controls are load, shift, done, and gc_count.
- The FSM and address/index counters stay in `strand_feeder`.

## Test plan
- Reset, then `load_on`=1 for 3 strands, STRAND_LEN=4, `base_ready`=1, memory words 0x1B, 0xE4, 0x00:
  - bases are 3,2,1,0 / 0,1,2,3 / 0,0,0,0;
  - three `cor_ready` pulses 9 cycles apart;
  - `strand_idx`=3 at the end.
- `base_ready` toggled 1010…: `base` holds while not ready, no base is lost or duplicated, and `cor_ready` comes only after the 4th handshake.
- `load_on` drops after the final `cor_ready` with upstream one-cycle lag: GUARD prevents a 4th FETCH, so `mem_rd_en` count equals 3.
- `rst` asserted in the second SHIFT cycle of strand 1:
  - all outputs 0 in the same cycle;
  - after release, `mem_addr`=0 is refetched.
- ADDR_W=2, 5 strands: `mem_addr` sequence is 0,1,2,3,0.
- `STRAND_FEEDER_GC_EN`, word 0x66 (bases 2,1,2,1): `gc_count`=4 at `cor_ready`. Word 0xCC (0,3,0,3): `gc_count`=0.
